// File: rtl/dir_pkg.sv
// Package: dir_pkg
// Purpose: shared definitions for the directory request sequencer. It holds the coherence
//          opcodes, the per-cache MSI state encodings and the sequencer FSM state type.
// Ports:   none (package only).
package dir_pkg;

    // Coherence opcodes carried on request and queue-allocation interfaces.
    localparam logic [2:0] OpNoop  = 3'd0;
    localparam logic [2:0] OpReply = 3'd2;
    localparam logic [2:0] OpRd    = 3'd3;
    localparam logic [2:0] OpWr    = 3'd4;
    localparam logic [2:0] OpInv   = 3'd5;
    localparam logic [2:0] OpUpd   = 3'd6;
    localparam logic [2:0] OpRwitm = 3'd7;
    // Read-and-invalidate snoop shares its encoding with RWITM.
    localparam logic [2:0] OpRinv  = 3'd7;

    // Per-cache directory state, stored as {M,S}.
    localparam logic [1:0] MsiI = 2'b00;
    localparam logic [1:0] MsiS = 2'b01;
    localparam logic [1:0] MsiM = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitAck,
        StDone
    } seq_state_e;

endpackage

// File: rtl/dir_fanout_decode.sv
// Module: dir_fanout_decode
// Purpose: combinational fan-out decode for one latched coherence request. From the opcode,
//          source, destination and the snapshot of all cache states it produces the queue
//          target masks with their opcodes, the set of snooped caches, the number of acks to
//          collect, and the directory state to write back on completion.
// Ports:
//   op_i, src_i, dest_i, state_i        latched request and state snapshot
//   inst_tgt_o / inst_op_o              per-cache instr-queue targets and opcodes
//   data_tgt_o / data_op_o              per-cache data-queue targets and opcodes
//   mem_inst_tgt_o / mem_inst_op_o      memory instr-queue target and opcode
//   mem_data_tgt_o / mem_data_op_o      memory data-queue target and opcode
//   snoop_tgt_o, ack_cnt_o              caches other than src that must ack, and their count
//   next_state_o                        updated per-cache state
module dir_fanout_decode
    import dir_pkg::*;
#(
    parameter int unsigned N_CACHE   = 2,
    parameter int unsigned ACK_CNT_W = 4,
    parameter int unsigned SRC_W     = $clog2(N_CACHE + 1)
) (
    input  logic [2:0]           op_i,
    input  logic [SRC_W-1:0]     src_i,
    input  logic [SRC_W-1:0]     dest_i,
    input  logic [2*N_CACHE-1:0] state_i,
    output logic [N_CACHE-1:0]   inst_tgt_o,
    output logic [3*N_CACHE-1:0] inst_op_o,
    output logic [N_CACHE-1:0]   data_tgt_o,
    output logic [3*N_CACHE-1:0] data_op_o,
    output logic                 mem_inst_tgt_o,
    output logic [2:0]           mem_inst_op_o,
    output logic                 mem_data_tgt_o,
    output logic [2:0]           mem_data_op_o,
    output logic [N_CACHE-1:0]   snoop_tgt_o,
    output logic [ACK_CNT_W-1:0] ack_cnt_o,
    output logic [2*N_CACHE-1:0] next_state_o
);

    logic [N_CACHE-1:0] src_hot, dest_hot;
    logic [N_CACHE-1:0] valid_all, s_all, m_all;
    logic [N_CACHE-1:0] valid_oth, s_oth, m_oth;
    logic               src_ok, src_is_cache;

    always_comb begin
        src_hot   = '0;
        dest_hot  = '0;
        valid_all = '0;
        s_all     = '0;
        m_all     = '0;
        for (int i = 0; i < N_CACHE; i++) begin
            src_hot[i]   = src_i == SRC_W'(i);
            dest_hot[i]  = dest_i == SRC_W'(i);
            valid_all[i] = state_i[2*i +: 2] != MsiI;
            s_all[i]     = state_i[2*i +: 2] == MsiS;
            m_all[i]     = state_i[2*i +: 2] == MsiM;
        end
    end

    assign valid_oth    = valid_all & ~src_hot;
    assign s_oth        = s_all & ~src_hot;
    assign m_oth        = m_all & ~src_hot;
    // Index N_CACHE is memory; anything above it is an illegal requester.
    assign src_ok       = src_i <= SRC_W'(N_CACHE);
    assign src_is_cache = |src_hot;

    always_comb begin
        inst_tgt_o     = '0;
        inst_op_o      = '0;
        data_tgt_o     = '0;
        data_op_o      = '0;
        mem_inst_tgt_o = 1'b0;
        mem_inst_op_o  = '0;
        mem_data_tgt_o = 1'b0;
        mem_data_op_o  = '0;
        next_state_o   = state_i;
        if (src_ok) begin
            case (op_i)
                OpRd: begin
                    if (|valid_oth) begin
                        inst_tgt_o = valid_oth;
                    end else begin
                        mem_inst_tgt_o = 1'b1;
                        mem_inst_op_o  = OpRd;
                    end
                    for (int i = 0; i < N_CACHE; i++) begin
                        if (valid_oth[i]) inst_op_o[3*i +: 3] = OpRd;
                        if (src_hot[i] || m_oth[i]) next_state_o[2*i +: 2] = MsiS;
                    end
                end
                OpWr: begin
                    if (src_is_cache) begin
                        mem_data_tgt_o = 1'b1;
                        mem_data_op_o  = OpWr;
                    end else begin
                        data_tgt_o = dest_hot;
                        for (int i = 0; i < N_CACHE; i++) begin
                            if (dest_hot[i]) data_op_o[3*i +: 3] = OpWr;
                        end
                    end
                end
                OpInv: begin
                    if (|(src_hot & m_all)) begin
                        mem_data_tgt_o = 1'b1;
                        mem_data_op_o  = OpWr;
                    end
                    for (int i = 0; i < N_CACHE; i++) begin
                        if (src_hot[i]) next_state_o[2*i +: 2] = MsiI;
                    end
                end
                OpReply: begin
                    data_tgt_o = dest_hot;
                    for (int i = 0; i < N_CACHE; i++) begin
                        if (dest_hot[i]) data_op_o[3*i +: 3] = OpWr;
                    end
                end
                OpUpd: begin
                    inst_tgt_o = s_oth | (src_hot & s_all);
                    for (int i = 0; i < N_CACHE; i++) begin
                        if (s_oth[i]) inst_op_o[3*i +: 3] = OpInv;
                        else if (src_hot[i] && s_all[i]) inst_op_o[3*i +: 3] = OpUpd;
                        next_state_o[2*i +: 2] = src_hot[i] ? MsiM : MsiI;
                    end
                end
                OpRwitm: begin
                    if (|valid_oth) begin
                        inst_tgt_o = valid_oth | src_hot;
                    end else begin
                        mem_inst_tgt_o = 1'b1;
                        mem_inst_op_o  = OpRd;
                    end
                    for (int i = 0; i < N_CACHE; i++) begin
                        if (valid_oth[i]) inst_op_o[3*i +: 3] = OpRinv;
                        else if (src_hot[i] && |valid_oth) inst_op_o[3*i +: 3] = OpUpd;
                        next_state_o[2*i +: 2] = src_hot[i] ? MsiM : MsiI;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Only snoops to caches other than the requester are acknowledged.
    assign snoop_tgt_o = inst_tgt_o & ~src_hot;

    always_comb begin
        ack_cnt_o = '0;
        for (int i = 0; i < N_CACHE; i++) begin
            ack_cnt_o = ack_cnt_o + ACK_CNT_W'(snoop_tgt_o[i]);
        end
    end

endmodule

// File: rtl/directory_req_sequencer.sv
// Module: directory_req_sequencer
// Purpose: accepts one coherence request at a time, snapshots every cache's MSI state, issues
//          all queue allocations together once no targeted queue is full, collects snoop acks
//          and returns the updated directory state with a one-cycle done pulse.
// Ports:
//   clk_i, rst_ni                          clock, asynchronous active-low reset
//   req_valid_i/req_ready_o                request handshake (ready only when idle)
//   req_op_i, req_src_i, req_dest_i        request fields; cur_state_i = per-cache state {M,S}
//   cq_inst_*/cq_data_*                    per-cache instr/data queue alloc, opcode, full
//   mem_inst_*/mem_data_*                  memory instr/data queue alloc, opcode, full
//   snoop_ack_i                            per-cache snoop completion pulses
//   done_o, next_state_o                   completion pulse and updated state (valid with done)
//   timeout_err_o                          sticky watchdog flag, only with DIR_SEQ_TIMEOUT_EN
// Configuration: define DIR_SEQ_TIMEOUT_EN to add an 8-bit WAIT_ACK watchdog that forces
//          completion with the snapshot state after 255 cycles and sets timeout_err_o.
module directory_req_sequencer
    import dir_pkg::*;
#(
    parameter int unsigned N_CACHE   = 2,
    parameter int unsigned ACK_CNT_W = 4,
    parameter int unsigned SRC_W     = $clog2(N_CACHE + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [2:0]           req_op_i,
    input  logic [SRC_W-1:0]     req_src_i,
    input  logic [SRC_W-1:0]     req_dest_i,
    input  logic [2*N_CACHE-1:0] cur_state_i,
    output logic [N_CACHE-1:0]   cq_inst_alloc_o,
    output logic [3*N_CACHE-1:0] cq_inst_op_o,
    input  logic [N_CACHE-1:0]   cq_inst_full_i,
    output logic [N_CACHE-1:0]   cq_data_alloc_o,
    output logic [3*N_CACHE-1:0] cq_data_op_o,
    input  logic [N_CACHE-1:0]   cq_data_full_i,
    output logic                 mem_inst_alloc_o,
    output logic [2:0]           mem_inst_op_o,
    input  logic                 mem_inst_full_i,
    output logic                 mem_data_alloc_o,
    output logic [2:0]           mem_data_op_o,
    input  logic                 mem_data_full_i,
    input  logic [N_CACHE-1:0]   snoop_ack_i,
    output logic                 done_o,
    output logic [2*N_CACHE-1:0] next_state_o
`ifdef DIR_SEQ_TIMEOUT_EN
    ,
    output logic                 timeout_err_o
`endif
);

    seq_state_e             fsm_q, fsm_d;
    logic [2:0]             op_q, op_d;
    logic [SRC_W-1:0]       src_q, src_d, dest_q, dest_d;
    logic [2*N_CACHE-1:0]   snap_q, snap_d;
    logic [ACK_CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic [N_CACHE-1:0]     ack_mask_q, ack_mask_d;

    logic [N_CACHE-1:0]     dec_inst_tgt, dec_data_tgt, dec_snoop_tgt;
    logic [3*N_CACHE-1:0]   dec_inst_op, dec_data_op;
    logic                   dec_mem_inst_tgt, dec_mem_data_tgt;
    logic [2:0]             dec_mem_inst_op, dec_mem_data_op;
    logic [ACK_CNT_W-1:0]   dec_ack_cnt, ack_pop;
    logic [2*N_CACHE-1:0]   dec_next_state, done_state;
    logic [N_CACHE-1:0]     ack_hits;
    logic                   blocked, issue_fire;

    dir_fanout_decode #(
        .N_CACHE   (N_CACHE),
        .ACK_CNT_W (ACK_CNT_W),
        .SRC_W     (SRC_W)
    ) u_decode (
        .op_i           (op_q),
        .src_i          (src_q),
        .dest_i         (dest_q),
        .state_i        (snap_q),
        .inst_tgt_o     (dec_inst_tgt),
        .inst_op_o      (dec_inst_op),
        .data_tgt_o     (dec_data_tgt),
        .data_op_o      (dec_data_op),
        .mem_inst_tgt_o (dec_mem_inst_tgt),
        .mem_inst_op_o  (dec_mem_inst_op),
        .mem_data_tgt_o (dec_mem_data_tgt),
        .mem_data_op_o  (dec_mem_data_op),
        .snoop_tgt_o    (dec_snoop_tgt),
        .ack_cnt_o      (dec_ack_cnt),
        .next_state_o   (dec_next_state)
    );

    // Full bits of queues this request does not target never hold up the issue.
    assign blocked = |(dec_inst_tgt & cq_inst_full_i) | |(dec_data_tgt & cq_data_full_i) |
                     (dec_mem_inst_tgt & mem_inst_full_i) | (dec_mem_data_tgt & mem_data_full_i);
    assign issue_fire = (fsm_q == StIssue) && !blocked;

    assign cq_inst_alloc_o  = issue_fire ? dec_inst_tgt : '0;
    assign cq_inst_op_o     = issue_fire ? dec_inst_op : '0;
    assign cq_data_alloc_o  = issue_fire ? dec_data_tgt : '0;
    assign cq_data_op_o     = issue_fire ? dec_data_op : '0;
    assign mem_inst_alloc_o = issue_fire & dec_mem_inst_tgt;
    assign mem_inst_op_o    = issue_fire ? dec_mem_inst_op : '0;
    assign mem_data_alloc_o = issue_fire & dec_mem_data_tgt;
    assign mem_data_op_o    = issue_fire ? dec_mem_data_op : '0;

    assign req_ready_o  = fsm_q == StIdle;
    assign done_o       = fsm_q == StDone;
    assign next_state_o = done_o ? done_state : '0;

    // Clearing mask bits as they arrive makes duplicate acks harmless.
    assign ack_hits = snoop_ack_i & ack_mask_q;

    always_comb begin
        ack_pop = '0;
        for (int i = 0; i < N_CACHE; i++) begin
            ack_pop = ack_pop + ACK_CNT_W'(ack_hits[i]);
        end
    end

`ifdef DIR_SEQ_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       to_hit_q, to_hit_d;
    logic       timeout_err_q, timeout_err_d;

    assign timeout_err_o = timeout_err_q;
    assign done_state    = to_hit_q ? snap_q : dec_next_state;
`else
    assign done_state    = dec_next_state;
`endif

    always_comb begin
        fsm_d      = fsm_q;
        op_d       = op_q;
        src_d      = src_q;
        dest_d     = dest_q;
        snap_d     = snap_q;
        ack_cnt_d  = ack_cnt_q;
        ack_mask_d = ack_mask_q;
`ifdef DIR_SEQ_TIMEOUT_EN
        wdog_d        = (fsm_q == StWaitAck) ? wdog_q + 8'd1 : 8'd0;
        to_hit_d      = to_hit_q;
        timeout_err_d = timeout_err_q;
`endif
        unique case (fsm_q)
            StIdle: begin
                if (req_valid_i) begin
                    op_d       = req_op_i;
                    src_d      = req_src_i;
                    dest_d     = req_dest_i;
                    snap_d     = cur_state_i;
                    ack_cnt_d  = '0;
                    ack_mask_d = '0;
                    fsm_d      = StIssue;
`ifdef DIR_SEQ_TIMEOUT_EN
                    to_hit_d   = 1'b0;
`endif
                end
            end
            StIssue: begin
                if (!blocked) begin
                    ack_cnt_d  = dec_ack_cnt;
                    ack_mask_d = dec_snoop_tgt;
                    fsm_d      = (dec_ack_cnt == '0) ? StDone : StWaitAck;
                end
            end
            StWaitAck: begin
                ack_cnt_d  = ack_cnt_q - ack_pop;
                ack_mask_d = ack_mask_q & ~snoop_ack_i;
                if (ack_cnt_q == ack_pop) begin
                    fsm_d = StDone;
                end
`ifdef DIR_SEQ_TIMEOUT_EN
                // wdog_q counts completed WAIT_ACK cycles; this is the 255th.
                else if (wdog_q == 8'd254) begin
                    fsm_d         = StDone;
                    to_hit_d      = 1'b1;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            StDone: begin
                fsm_d = StIdle;
            end
            default: begin
                fsm_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q      <= StIdle;
            op_q       <= '0;
            src_q      <= '0;
            dest_q     <= '0;
            snap_q     <= '0;
            ack_cnt_q  <= '0;
            ack_mask_q <= '0;
`ifdef DIR_SEQ_TIMEOUT_EN
            wdog_q        <= '0;
            to_hit_q      <= 1'b0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            fsm_q      <= fsm_d;
            op_q       <= op_d;
            src_q      <= src_d;
            dest_q     <= dest_d;
            snap_q     <= snap_d;
            ack_cnt_q  <= ack_cnt_d;
            ack_mask_q <= ack_mask_d;
`ifdef DIR_SEQ_TIMEOUT_EN
            wdog_q        <= wdog_d;
            to_hit_q      <= to_hit_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_directory_req_sequencer.sv
// Testbench for directory_req_sequencer with four caches. Directed scenarios plus randomized
// requests, queue-full patterns and snoop acks are checked against a behavioural model.
module tb_directory_req_sequencer;

    localparam int NC = 4;
    localparam int SW = 3;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          req_valid, req_ready;
    logic [2:0]    req_op;
    logic [SW-1:0] req_src, req_dest;
    logic [2*NC-1:0] cur_state;
    logic [NC-1:0]   cq_inst_alloc, cq_inst_full, cq_data_alloc, cq_data_full, snoop_ack;
    logic [3*NC-1:0] cq_inst_op, cq_data_op;
    logic            mem_inst_alloc, mem_inst_full, mem_data_alloc, mem_data_full;
    logic [2:0]      mem_inst_op, mem_data_op;
    logic            done;
    logic [2*NC-1:0] next_state;
`ifdef DIR_SEQ_TIMEOUT_EN
    logic            timeout_err;
`endif

    logic [9:0]  alloc_w;
    logic [29:0] op_w;
    assign alloc_w = {mem_data_alloc, mem_inst_alloc, cq_data_alloc, cq_inst_alloc};
    assign op_w    = {mem_data_op, mem_inst_op, cq_data_op, cq_inst_op};

    int total = 0;
    int bad   = 0;

    directory_req_sequencer #(
        .N_CACHE   (NC),
        .ACK_CNT_W (AW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_op_i         (req_op),
        .req_src_i        (req_src),
        .req_dest_i       (req_dest),
        .cur_state_i      (cur_state),
        .cq_inst_alloc_o  (cq_inst_alloc),
        .cq_inst_op_o     (cq_inst_op),
        .cq_inst_full_i   (cq_inst_full),
        .cq_data_alloc_o  (cq_data_alloc),
        .cq_data_op_o     (cq_data_op),
        .cq_data_full_i   (cq_data_full),
        .mem_inst_alloc_o (mem_inst_alloc),
        .mem_inst_op_o    (mem_inst_op),
        .mem_inst_full_i  (mem_inst_full),
        .mem_data_alloc_o (mem_data_alloc),
        .mem_data_op_o    (mem_data_op),
        .mem_data_full_i  (mem_data_full),
        .snoop_ack_i      (snoop_ack),
        .done_o           (done),
        .next_state_o     (next_state)
`ifdef DIR_SEQ_TIMEOUT_EN
        ,
        .timeout_err_o    (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected fan-out written straight from the request rules, using per-cache integer states.
    function automatic void model(input logic [2:0] op, input int src, input int dest,
                                  input logic [2*NC-1:0] st, output logic [9:0] alloc,
                                  output logic [29:0] ops, output logic [NC-1:0] snoop,
                                  output logic [2*NC-1:0] nst);
        logic [NC-1:0]   itgt, dtgt;
        logic [3*NC-1:0] iop, dop;
        logic            mi, md;
        logic [2:0]      miop, mdop;
        int              s[NC];
        int              n_oth;
        bit              cache_src;
        itgt = '0; dtgt = '0; iop = '0; dop = '0;
        mi = 1'b0; md = 1'b0; miop = '0; mdop = '0;
        nst = st;
        n_oth = 0;
        cache_src = src < NC;
        for (int i = 0; i < NC; i++) begin
            s[i] = int'(st[2*i +: 2]);
            if (i != src && s[i] != 0) n_oth++;
        end
        if (src <= NC) begin
            case (op)
                3'd3: begin
                    for (int i = 0; i < NC; i++) begin
                        if (i != src && s[i] != 0) begin itgt[i] = 1'b1; iop[3*i +: 3] = 3'd3; end
                        if (i == src || s[i] == 2) nst[2*i +: 2] = 2'b01;
                    end
                    if (n_oth == 0) begin mi = 1'b1; miop = 3'd3; end
                end
                3'd4: begin
                    if (cache_src) begin md = 1'b1; mdop = 3'd4; end
                    else if (dest < NC) begin dtgt[dest] = 1'b1; dop[3*dest +: 3] = 3'd4; end
                end
                3'd5: begin
                    if (cache_src) begin
                        if (s[src] == 2) begin md = 1'b1; mdop = 3'd4; end
                        nst[2*src +: 2] = 2'b00;
                    end
                end
                3'd2: begin
                    if (dest < NC) begin dtgt[dest] = 1'b1; dop[3*dest +: 3] = 3'd4; end
                end
                3'd6, 3'd7: begin
                    for (int i = 0; i < NC; i++) begin
                        if (op == 3'd6 && i != src && s[i] == 1) begin
                            itgt[i] = 1'b1; iop[3*i +: 3] = 3'd5;
                        end
                        if (op == 3'd7 && i != src && s[i] != 0) begin
                            itgt[i] = 1'b1; iop[3*i +: 3] = 3'd7;
                        end
                        nst[2*i +: 2] = (i == src) ? 2'b10 : 2'b00;
                    end
                    if (cache_src && ((op == 3'd6 && s[src] == 1) || (op == 3'd7 && n_oth > 0))) begin
                        itgt[src] = 1'b1; iop[3*src +: 3] = 3'd6;
                    end
                    if (op == 3'd7 && n_oth == 0) begin mi = 1'b1; miop = 3'd3; end
                end
                default: begin
                end
            endcase
        end
        snoop = itgt;
        if (cache_src) snoop[src] = 1'b0;
        alloc = {md, mi, dtgt, itgt};
        ops   = {mdop, miop, dop, iop};
    endfunction

    // Randomizes queue-full bits, acks and the (ignored) request fields.
    task automatic drive_noise(input bit all_full, input bit ack_en);
        for (int i = 0; i < NC; i++) begin
            cq_inst_full[i] = all_full | ($urandom_range(0, 7) == 0);
            cq_data_full[i] = all_full | ($urandom_range(0, 7) == 0);
            snoop_ack[i]    = ack_en & ($urandom_range(0, 2) == 0);
        end
        mem_inst_full = all_full | ($urandom_range(0, 7) == 0);
        mem_data_full = all_full | ($urandom_range(0, 7) == 0);
        req_op    = 3'($urandom);
        req_src   = SW'($urandom);
        req_dest  = SW'($urandom);
        cur_state = (2*NC)'($urandom);
    endtask

    // mode 0: normal; 1: reset during WAIT_ACK; 2: acks withheld (watchdog)
    task automatic run_txn(input logic [2:0] op, input int src, input int dest,
                           input logic [2*NC-1:0] st, input int hold, input int mode);
        logic [9:0]      e_alloc;
        logic [29:0]     e_ops;
        logic [NC-1:0]   pend;
        logic [2*NC-1:0] e_nst;
        logic [9:0]      tgt_full;
        bit              issued;
        int              cyc;
        model(op, src, dest, st, e_alloc, e_ops, pend, e_nst);
        @(negedge clk);
        drive_noise(1'b0, 1'b1);
        #1;
        check_eq("idle_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_src   = SW'(src);
        req_dest  = SW'(dest);
        cur_state = st;
        @(negedge clk);
        req_valid = 1'b0;
        issued = 1'b0;
        cyc = 0;
        while (!issued && cyc < 200) begin
            drive_noise(cyc < hold, 1'b1);
            #1;
            tgt_full = {mem_data_full, mem_inst_full, cq_data_full, cq_inst_full};
            if ((tgt_full & e_alloc) != '0) begin
                check_eq("stall_alloc", alloc_w, 0);
            end else begin
                check_eq("issue_alloc", alloc_w, e_alloc);
                check_eq("issue_op", op_w, e_ops);
                issued = 1'b1;
            end
            check_eq("issue_done", done, 0);
            check_eq("issue_ready", req_ready, 0);
            @(negedge clk);
            cyc++;
        end
        if (!issued) check_eq("issue_bound", 0, 1);
        if (mode == 2) begin
`ifdef DIR_SEQ_TIMEOUT_EN
            cyc = 0;
            drive_noise(1'b0, 1'b0);
            #1;
            while (!done && cyc < 300) begin
                cyc++;
                @(negedge clk);
                drive_noise(1'b0, 1'b0);
                #1;
            end
            check_eq("wdog_cycles", cyc, 255);
            check_eq("wdog_done", done, 1);
            check_eq("wdog_err", timeout_err, 1);
            check_eq("wdog_state", next_state, st);
`endif
        end else begin
            cyc = 0;
            while (pend != '0 && cyc < 200) begin
                drive_noise(1'b0, mode == 0);
                #1;
                check_eq("wait_alloc", alloc_w, 0);
                check_eq("wait_done", done, 0);
                if (mode == 1 && cyc == 2) begin
                    rst_n = 1'b0;
                    #1;
                    check_eq("abort_alloc", alloc_w, 0);
                    check_eq("abort_op", op_w, 0);
                    check_eq("abort_done", done, 0);
                    check_eq("abort_nst", next_state, 0);
                    check_eq("abort_ready", req_ready, 1);
                    @(negedge clk);
                    rst_n = 1'b1;
                    return;
                end
                pend = pend & ~snoop_ack;
                @(negedge clk);
                cyc++;
            end
            if (pend != '0) check_eq("ack_bound", pend, 0);
            drive_noise(1'b0, 1'b1);
            #1;
            check_eq("done_pulse", done, 1);
            check_eq("done_state", next_state, e_nst);
            check_eq("done_ready", req_ready, 0);
        end
        @(negedge clk);
        drive_noise(1'b0, 1'b1);
        #1;
        check_eq("post_ready", req_ready, 1);
        check_eq("post_done", done, 0);
    endtask

    initial begin
        logic [2*NC-1:0] st;
        int              src;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_op        = '0;
        req_src       = '0;
        req_dest      = '0;
        cur_state     = '0;
        cq_inst_full  = '0;
        cq_data_full  = '0;
        mem_inst_full = 1'b0;
        mem_data_full = 1'b0;
        snoop_ack     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_alloc", alloc_w, 0);
        check_eq("rst_op", op_w, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_nst", next_state, 0);

        run_txn(3'd3, 0, 0, 8'h08, 0, 0);   // RD, cache1=M
        run_txn(3'd3, 1, 0, 8'h00, 0, 0);   // RD, all invalid -> memory
        run_txn(3'd7, 0, 0, 8'h04, 3, 0);   // RWITM, cache1=S, queues full 3 cycles
        run_txn(3'd6, 0, 0, 8'h54, 0, 0);   // UPD, caches 1-3 in S
        run_txn(3'd6, 1, 0, 8'h44, 0, 0);   // UPD, src in S gets UPD
        run_txn(3'd4, 4, 1, 8'h00, 0, 0);   // WR from memory to cache1
        run_txn(3'd4, 2, 0, 8'h20, 2, 0);   // WR from cache -> memory data
        run_txn(3'd5, 3, 0, 8'h80, 0, 0);   // INV, src in M
        run_txn(3'd2, 4, 3, 8'h19, 0, 0);   // REPLY to cache3
        run_txn(3'd2, 4, 5, 8'h19, 0, 0);   // REPLY to illegal dest
        run_txn(3'd0, 0, 0, 8'h56, 0, 0);   // NOOP
        run_txn(3'd1, 1, 0, 8'h56, 0, 0);   // reserved opcode
        run_txn(3'd3, 6, 0, 8'h56, 0, 0);   // illegal src
        run_txn(3'd6, 0, 0, 8'h54, 0, 1);   // reset during WAIT_ACK
        run_txn(3'd3, 0, 0, 8'h08, 0, 0);   // clean operation after abort
`ifdef DIR_SEQ_TIMEOUT_EN
        run_txn(3'd6, 0, 0, 8'h54, 0, 2);   // acks withheld
`endif

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NC; i++) st[2*i +: 2] = 2'($urandom_range(0, 2));
            src = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7))
                                                : int'($urandom_range(0, 4));
            run_txn(3'($urandom_range(0, 7)), src, int'($urandom_range(0, 5)), st,
                    int'($urandom_range(0, 3)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
